// File: rtl/str_to_num_arb_if.sv
// str_to_num_arb_if
//   Bundles every handshake bus around the shared str_to_num parser arbiter.
//   s_*  : N upstream character streams. Requester i uses s_dtm[8i+7:8i].
//   p_*  : a single character stream into the parser.
//   r_*  : the numeric result coming back from the parser.
//   m_*  : the tagged result sent downstream (m_id names the requester).
//   Modports:
//     slave  - the arbiter's view.
//     master - the surrounding system's view (sources, parser, sink).
interface str_to_num_arb_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [8*N-1:0] s_dtm;
  logic [N-1:0]   s_vld;
  logic [N-1:0]   s_rdy;
  logic [7:0]     p_dtm;
  logic           p_vld;
  logic           p_rdy;
  logic [31:0]    r_dtm;
  logic           r_vld;
  logic           r_rdy;
  logic [31:0]    m_dtm;
  logic [IDW-1:0] m_id;
  logic           m_vld;
  logic           m_rdy;

  modport slave (
    input  s_dtm, s_vld,
    output s_rdy,
    output p_dtm, p_vld,
    input  p_rdy,
    input  r_dtm, r_vld,
    output r_rdy,
    output m_dtm, m_id, m_vld,
    input  m_rdy
  );

  modport master (
    output s_dtm, s_vld,
    input  s_rdy,
    input  p_dtm, p_vld,
    output p_rdy,
    output r_dtm, r_vld,
    input  r_rdy,
    input  m_dtm, m_id, m_vld,
    output m_rdy
  );
endinterface

// File: rtl/str_to_num_arb.sv
// str_to_num_arb
//   Shares a single str_to_num parser among N ASCII character streams.
//   A grant covers one whole message: the owner's characters are passed
//   straight through to the parser up to and including the first non-digit
//   delimiter. The arbiter then waits for the parser's number, forwards it
//   downstream tagged with the owner id, and rotates priority round-robin.
//   Ports:
//     clk    - system clock, rising edge.
//     rst_n  - asynchronous active-low reset.
//     bus    - str_to_num_arb_if.slave carrying the s_*, p_*, r_* and m_*
//              handshake buses (see the interface header).
module str_to_num_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  str_to_num_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_NUM = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] owner_reg, owner_next;

  logic [7:0]     chan_dtm [N];
  logic [N-1:0]   grant_rdy;
  logic [IDW-1:0] winner;
  logic           winner_vld;
  logic [7:0]     owner_dtm;
  logic           owner_vld;
  logic           owner_is_digit;
  logic           p_vld_c;
  logic           r_rdy_c;
  logic           m_vld_c;

  // Unpack the flat character bus and build the per-requester ready
  // vector: only the current owner sees the parser's ready, and only
  // while a message is streaming.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_dtm[gi]  = bus.s_dtm[8*gi +: 8];
      assign grant_rdy[gi] = (state_reg == STREAM) &&
                             (owner_reg == IDW'(gi)) && bus.p_rdy;
    end
  endgenerate

  // Round-robin pick: scan ptr, ptr+1, ... wrapping at N-1. The loop runs
  // from the farthest offset down so the nearest requester overwrites
  // any farther one. One extra index bit holds ptr+k before the wrap.
  always_comb begin
    logic [IDW:0] idx;
    idx        = '0;
    winner     = '0;
    winner_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) begin
        idx = idx - (IDW+1)'(N);
      end
      if (bus.s_vld[idx[IDW-1:0]]) begin
        winner     = idx[IDW-1:0];
        winner_vld = 1'b1;
      end
    end
  end

  assign owner_dtm      = chan_dtm[owner_reg];
  assign owner_vld      = bus.s_vld[owner_reg];
  assign owner_is_digit = (owner_dtm >= 8'h30) && (owner_dtm <= 8'h39);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    p_vld_c    = 1'b0;
    r_rdy_c    = 1'b0;
    m_vld_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (winner_vld) begin
          owner_next = winner;
          state_next = STREAM;
        end
      end
      STREAM: begin
        // The result side stays closed here; a premature r_vld simply
        // waits until the delimiter has gone through.
        p_vld_c = owner_vld;
        if (owner_vld && bus.p_rdy && !owner_is_digit) begin
          state_next = WAIT_NUM;
        end
      end
      WAIT_NUM: begin
        m_vld_c = bus.r_vld;
        r_rdy_c = bus.m_rdy;
        if (bus.r_vld && bus.m_rdy) begin
          state_next = IDLE;
          ptr_next   = (owner_reg == IDW'(N - 1)) ? '0 : owner_reg + IDW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  // All outputs are decoded from the registered state, so an asynchronous
  // reset forces every valid/ready low without waiting for a clock edge.
  assign bus.s_rdy = grant_rdy;
  assign bus.p_dtm = owner_dtm;
  assign bus.p_vld = p_vld_c;
  assign bus.r_rdy = r_rdy_c;
  assign bus.m_dtm = bus.r_dtm;
  assign bus.m_id  = owner_reg;
  assign bus.m_vld = m_vld_c;

endmodule

// File: tb/tb_str_to_num_arb.sv
// tb_str_to_num_arb
//   Directed bench for str_to_num_arb. The bench plays the N character
//   sources (queues of characters), a behavioural str_to_num parser and
//   the downstream sink. All driving happens on the falling edge; outputs
//   are sampled 1 time unit after it.
module tb_str_to_num_arb;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  str_to_num_arb_if #(.N(N), .IDW(IDW)) bus ();

  str_to_num_arb #(.N(N), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]     src_q [N][$];
  logic [IDW-1:0] res_id[$];
  logic [31:0]    res_val[$];
  logic [7:0]     p_log[$];
  logic [31:0]    acc;

  logic [N-1:0]   smp_s_rdy;
  logic           smp_p_vld;
  logic           smp_r_rdy;
  logic           smp_m_vld;
  logic [31:0]    smp_m_dtm;

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        bus.s_vld[i]         = 1'b1;
        bus.s_dtm[8*i +: 8]  = src_q[i][0];
      end else begin
        bus.s_vld[i]         = 1'b0;
        bus.s_dtm[8*i +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic push_str(input int i, input string s);
    for (int k = 0; k < s.len(); k++) src_q[i].push_back(s[k]);
    drive_src();
  endtask

  task automatic clear_logs();
    res_id.delete();
    res_val.delete();
    p_log.delete();
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic step();
    logic [N-1:0] s_fire;
    logic         p_fire, r_fire, m_fire;
    logic [7:0]   ch;
    #1;
    s_fire    = bus.s_vld & bus.s_rdy;
    p_fire    = bus.p_vld & bus.p_rdy;
    r_fire    = bus.r_vld & bus.r_rdy;
    m_fire    = bus.m_vld & bus.m_rdy;
    smp_s_rdy = bus.s_rdy;
    smp_p_vld = bus.p_vld;
    smp_r_rdy = bus.r_rdy;
    smp_m_vld = bus.m_vld;
    smp_m_dtm = bus.m_dtm;
    ch        = bus.p_dtm;
    if (m_fire) begin
      res_id.push_back(bus.m_id);
      res_val.push_back(bus.m_dtm);
    end
    if (p_fire) p_log.push_back(ch);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (s_fire[i]) void'(src_q[i].pop_front());
    end
    if (r_fire) bus.r_vld = 1'b0;
    if (p_fire) begin
      if (ch >= 8'h30 && ch <= 8'h39) begin
        acc = acc * 10 + 32'(ch - 8'h30);
      end else begin
        bus.r_vld = 1'b1;
        bus.r_dtm = acc;
        acc       = 0;
      end
    end
    drive_src();
  endtask

  task automatic run_results(input int n, input int budget);
    for (int c = 0; c < budget && res_val.size() < n; c++) step();
  endtask

  task automatic reset_env();
    for (int i = 0; i < N; i++) src_q[i].delete();
    acc       = 0;
    bus.r_vld = 1'b0;
    bus.r_dtm = 32'd0;
    bus.p_rdy = 1'b1;
    bus.m_rdy = 1'b1;
    drive_src();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reset_env();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic check_result(input string name, input int k,
                              input logic [31:0] exp_val, input logic [IDW-1:0] exp_id);
    logic [31:0]    got_val;
    logic [IDW-1:0] got_id;
    got_val = (k < res_val.size()) ? res_val[k] : 'x;
    got_id  = (k < res_id.size())  ? res_id[k]  : 'x;
    checks++;
    if (got_val !== exp_val) begin
      errors++;
      $display("FAIL %s_val[%0d]: got %0d expected %0d", name, k, got_val, exp_val);
    end
    checks++;
    if (got_id !== exp_id) begin
      errors++;
      $display("FAIL %s_id[%0d]: got %0d expected %0d", name, k, got_id, exp_id);
    end
  endtask

  task automatic test_reset();
    reset_env();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.s_rdy !== 4'b0000) begin errors++; $display("FAIL reset_s_rdy: got %b expected 0000", bus.s_rdy); end
    checks++;
    if (bus.p_vld !== 1'b0) begin errors++; $display("FAIL reset_p_vld: got %b expected 0", bus.p_vld); end
    checks++;
    if (bus.r_rdy !== 1'b0) begin errors++; $display("FAIL reset_r_rdy: got %b expected 0", bus.r_rdy); end
    checks++;
    if (bus.m_vld !== 1'b0) begin errors++; $display("FAIL reset_m_vld: got %b expected 0", bus.m_vld); end
    checks++;
    if (bus.m_id !== 2'd0) begin errors++; $display("FAIL reset_m_id: got %0d expected 0", bus.m_id); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [10:0] got_srdy, got_mvld;
    clear_logs();
    push_str(0, "123\n9\n");
    for (int k = 0; k < 11; k++) begin
      step();
      got_srdy[k] = smp_s_rdy[0];
      got_mvld[k] = smp_m_vld;
    end
    checks++;
    if (got_srdy !== 11'b00110011110) begin
      errors++; $display("FAIL single_s_rdy0_seq: got %b expected 00110011110", got_srdy);
    end
    checks++;
    if (got_mvld !== 11'b01000100000) begin
      errors++; $display("FAIL single_m_vld_seq: got %b expected 01000100000", got_mvld);
    end
    check_result("single", 0, 32'd123, 2'd0);
    check_result("single", 1, 32'd9, 2'd0);
    checks++;
    if (p_log.size() != 6) begin errors++; $display("FAIL single_char_count: got %0d expected 6", p_log.size()); end
    $display("test_single: results=%0d first=%0d", res_val.size(), (res_val.size() > 0) ? res_val[0] : 0);
  endtask

  task automatic test_contention();
    int s2_bad;
    do_reset();
    push_str(1, "45,");
    push_str(2, "6,");
    s2_bad = 0;
    for (int c = 0; c < 40 && res_val.size() < 1; c++) begin
      step();
      if (smp_s_rdy[2] !== 1'b0) s2_bad++;
    end
    run_results(2, 40);
    checks++;
    if (s2_bad != 0) begin errors++; $display("FAIL contention_s_rdy2: got %0d cycles high expected 0", s2_bad); end
    checks++;
    if (res_val.size() != 2) begin errors++; $display("FAIL contention_count: got %0d expected 2", res_val.size()); end
    check_result("contention", 0, 32'd45, 2'd1);
    check_result("contention", 1, 32'd6, 2'd2);
    $display("test_contention: results=%0d", res_val.size());
  endtask

  task automatic test_rotation();
    logic [IDW-1:0] exp_ids [6];
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < N; i++) push_str(i, "7\n7\n");
    run_results(6, 60);
    checks++;
    if (res_val.size() != 6) begin errors++; $display("FAIL rotation_count: got %0d expected 6", res_val.size()); end
    for (int k = 0; k < 6; k++) check_result("rotation", k, 32'd7, exp_ids[k]);
    $display("test_rotation: results=%0d", res_val.size());
  endtask

  task automatic test_backpressure();
    string exp_s;
    exp_s = "89 ";
    do_reset();
    bus.m_rdy = 1'b0;
    push_str(0, "89 ");
    for (int k = 0; k < 7; k++) begin
      bus.p_rdy = (k % 2 == 0);
      step();
    end
    bus.p_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (smp_m_vld !== 1'b1 || smp_m_dtm !== 32'd89) begin
        errors++; $display("FAIL bp_hold[%0d]: got m_vld=%b m_dtm=%0d expected 1/89", k, smp_m_vld, smp_m_dtm);
      end
      checks++;
      if (smp_r_rdy !== 1'b0 || smp_p_vld !== 1'b0 || smp_s_rdy !== 4'b0000) begin
        errors++; $display("FAIL bp_wait[%0d]: got r_rdy=%b p_vld=%b s_rdy=%b expected 0/0/0000",
                           k, smp_r_rdy, smp_p_vld, smp_s_rdy);
      end
    end
    bus.m_rdy = 1'b1;
    step();
    checks++;
    if (p_log.size() != 3) begin errors++; $display("FAIL bp_char_count: got %0d expected 3", p_log.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= p_log.size() || p_log[k] !== exp_s[k]) begin
        errors++; $display("FAIL bp_char[%0d]: got %h expected %h", k, (k < p_log.size()) ? p_log[k] : 8'hxx, exp_s[k]);
      end
    end
    check_result("bp", 0, 32'd89, 2'd0);
    $display("test_backpressure: chars=%0d results=%0d", p_log.size(), res_val.size());
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_str(1, "1\n");
    run_results(1, 20);
    push_str(3, "12");
    repeat (3) step();
    push_str(3, "3\n");
    #2;
    checks++;
    if (bus.p_vld !== 1'b1 || bus.s_rdy !== 4'b1000) begin
      errors++; $display("FAIL rmid_pre: got p_vld=%b s_rdy=%b expected 1/1000", bus.p_vld, bus.s_rdy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.s_rdy !== 4'b0000 || bus.p_vld !== 1'b0) begin
      errors++; $display("FAIL rmid_async_s: got s_rdy=%b p_vld=%b expected 0000/0", bus.s_rdy, bus.p_vld);
    end
    checks++;
    if (bus.r_rdy !== 1'b0 || bus.m_vld !== 1'b0 || bus.m_id !== 2'd0) begin
      errors++; $display("FAIL rmid_async_m: got r_rdy=%b m_vld=%b m_id=%0d expected 0/0/0", bus.r_rdy, bus.m_vld, bus.m_id);
    end
    reset_env();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    push_str(0, "5\n");
    push_str(3, "8\n");
    run_results(2, 40);
    check_result("rmid", 0, 32'd5, 2'd0);
    check_result("rmid", 1, 32'd8, 2'd3);
    $display("test_reset_mid: results=%0d", res_val.size());
  endtask

  task automatic test_stall();
    int s2_bad;
    do_reset();
    push_str(1, "3");
    push_str(2, "2\n");
    step();
    step();
    s2_bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (smp_s_rdy[2] !== 1'b0 || smp_p_vld !== 1'b0) s2_bad++;
    end
    checks++;
    if (s2_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", s2_bad); end
    push_str(1, "4\n");
    run_results(2, 40);
    check_result("stall", 0, 32'd34, 2'd1);
    check_result("stall", 1, 32'd2, 2'd2);
    $display("test_stall: results=%0d", res_val.size());
  endtask

  initial begin
    bus.s_dtm = '0;
    bus.s_vld = '0;
    bus.p_rdy = 1'b1;
    bus.r_dtm = '0;
    bus.r_vld = 1'b0;
    bus.m_rdy = 1'b1;
    acc       = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/str_to_num_arb.md
Name: str_to_num_arb

Overview:
- Shares one str_to_num parser among N independent ASCII character streams.
- Grants are message-granular and round-robin:
  - The arbiter locks onto one requester.
  - It forwards that requester's characters up to and including the first non-digit delimiter.
  - It waits for the parser's resulting number and returns it tagged with the requester id.
  - It then rotates priority.
- Sits between N upstream byte sources and a single str_to_num instance.

Parameters:
- N, 4, number of requesting character streams (>=2).
- IDW, 2, width of requester id; must equal clog2(N).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_dtm  input  8*N  packed request characters; requester i occupies bits [8i+7:8i].
- s_vld  input  N  per-requester character valid.
- s_rdy  output  N  per-requester character ready.
- p_dtm  output  8  character to parser (drives str_to_num s_dtm).
- p_vld  output  1  character valid to parser.
- p_rdy  input  1  parser character ready.
- r_dtm  input  32  parser result (from str_to_num n_dtm).
- r_vld  input  1  parser result valid.
- r_rdy  output  1  result ready to parser.
- m_dtm  output  32  tagged result to downstream.
- m_id  output  IDW  requester id owning m_dtm.
- m_vld  output  1  result valid downstream.
- m_rdy  input  1  downstream ready.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; ptr=0; owner=0.
  - Outputs: s_rdy=0, p_vld=0, r_rdy=0, m_vld=0. m_dtm and p_dtm are don't-care; m_id=0.
- Reset asserted mid-message:
  - The current message is abandoned.
  - The parser is not separately cleared; the system resets both together.
- Handshake: a transfer occurs on any rising edge where vld&rdy=1. Once vld is raised, the source holds data stable until the transfer.
- States: IDLE, STREAM, WAIT_NUM.
- IDLE:
  - All s_rdy=0, p_vld=0, r_rdy=0, m_vld=0.
  - If any s_vld is set, winner = first i with s_vld[i]=1, scanning ptr, ptr+1, ... wrapping at N-1 to 0.
  - owner<=winner; next state STREAM.
  - Grant latency: 1 cycle from s_vld to s_rdy eligibility.
- STREAM:
  - p_dtm = s_dtm[owner]; p_vld = s_vld[owner]; s_rdy[owner] = p_rdy; all other s_rdy=0.
  - Pure combinational pass-through; zero added latency per character.
  - On a transfer whose character is outside 8'h30..8'h39 (the delimiter), next state is WAIT_NUM.
  - Digit transfers stay in STREAM.
  - r_rdy=0, m_vld=0 in this state. A r_vld arriving here is a protocol violation and is held off (not consumed).
- WAIT_NUM:
  - p_vld=0; all s_rdy=0.
  - m_dtm=r_dtm; m_id=owner; m_vld=r_vld; r_rdy=m_rdy (pass-through).
  - On r_vld&m_rdy: next state IDLE; ptr<=(owner==N-1)?0:owner+1.
- m_id equals owner in every state; downstream qualifies it only with m_vld.
- Other requesters' s_vld are ignored while a grant is held; their characters stay pending and none is lost or reordered.
- Back-to-back messages:
  - Min gap between delimiter transfer and the next message's first character is 1 cycle of WAIT_NUM plus 1 IDLE cycle.
  - Ownership changes only through IDLE.
- A requester dropping s_vld mid-message keeps the grant; the arbiter waits indefinitely (no timeout).
- Fairness: a continuously requesting stream waits at most N-1 messages.

Test Plan:
- Single stream: requester 0 sends "123\n" with p_rdy=1 and m_rdy=1; parser returns 123.
  - Required: m_dtm=123, m_id=0, m_vld for one cycle.
  - Required: s_rdy[0] low for exactly the WAIT_NUM and IDLE cycles afterward.
- Contention: requesters 1 and 2 both valid from reset with "45," and "6,".
  - Required: requester 1 is served first (45, id 1), then requester 2 (6, id 2).
  - Required: s_rdy[2]=0 throughout requester 1's message.
- Rotation wrap: N=4, all four requesters continuously send "7\n".
  - Required: ids emitted 0,1,2,3,0,1.
- Backpressure:
  - p_rdy toggles 1,0,1,0 during "89 ". Required: each character transfers exactly once, in order.
  - m_rdy held 0 for 5 cycles with r_vld=1. Required: m_vld held, m_dtm=89 stable, state stays WAIT_NUM.
- Reset mid-message: assert rst_n=0 after "12" from requester 3.
  - Required: all rdy/vld outputs go low immediately (asynchronously).
  - Required: after release, requester 0 with "5\n" is granted first (ptr=0).
- Stall: requester 1 sends "3", then drops s_vld for 10 cycles while requester 2 is valid.
  - Required: the grant stays with 1 and requester 2 receives no s_rdy.
  - Required: when requester 1 then sends "4\n", m_dtm=34 and m_id=1.
